fifo_flagged: RTL

Parametrised synchronous FIFO that generalises the team's basic FIFO. It adds arbitrary (non-power-of-two) depth, an occupancy count, programmable almost-full and almost-empty thresholds, sticky overflow/underflow error flags, and a read-valid strobe. It is the standard buffering element between protocol front-ends (UART, SPI, I2C) and their bus-side engines.

---
 rtl/fifo_pkg.sv | 18 +
 rtl/fifo_ram.sv | 26 ++
 rtl/fifo_flagged.sv | 118 +++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO types: status bundle and count-width helper.
// Imported by fifo_ram, fifo_flagged and parent blocks.
package fifo_pkg;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// FIFO storage: N_SIZE x N_BITS, sync write, async read.
// Ports: clk, we, waddr, wdata, raddr, rdata.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int N_BITS = 8,
  parameter int N_SIZE = 4,
  parameter int AW     = $clog2(N_SIZE)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [N_BITS-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [N_BITS-1:0] rdata
);

  logic [N_BITS-1:0] mem [N_SIZE];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_flagged.sv
// Flagged FIFO: count, AF/AE thresholds, sticky errors, valid strobe.
// Ports: clk, rst_n, push, pop, data_in, clr_err -> data_out, data_valid,
// full, empty, almost_full, almost_empty, count, overflow, underflow.
// Define FIFO_FWFT_EN for first-word-fall-through read path.
module fifo_flagged
  import fifo_pkg::*;
#(
  parameter int N_BITS   = 8,
  parameter int N_SIZE   = 4,
  parameter int AF_LEVEL = N_SIZE - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [N_BITS-1:0]          data_in,
  input  logic                       clr_err,
  output logic [N_BITS-1:0]          data_out,
  output logic                       data_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(N_SIZE+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(N_SIZE);
  localparam int CW = cnt_w(N_SIZE);

  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [N_BITS-1:0] head;
  logic              pop_ok;
  logic              push_ok;
  logic              ovf_q;
  logic              unf_q;
  fifo_status_t      st;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(N_SIZE - 1)) ? '0 : p + 1'b1;
  endfunction

  // A full FIFO may still take a push when a pop frees the slot.
  assign pop_ok  = pop && !st.empty;
  assign push_ok = push && (!st.full || pop_ok);

  always_comb begin
    st              = '0;
    st.full         = (count == CW'(N_SIZE));
    st.empty        = (count == '0);
    st.almost_full  = (count >= CW'(AF_LEVEL));
    st.almost_empty = (count <= CW'(AE_LEVEL));
    st.overflow     = ovf_q;
    st.underflow    = unf_q;
  end

  assign full         = st.full;
  assign empty        = st.empty;
  assign almost_full  = st.almost_full;
  assign almost_empty = st.almost_empty;
  assign overflow     = st.overflow;
  assign underflow    = st.underflow;

  fifo_ram #(
    .N_BITS (N_BITS),
    .N_SIZE (N_SIZE),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= nxt(wr_ptr);
      if (pop_ok)  rd_ptr <= nxt(rd_ptr);
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Set wins over a coincident clear.
      if (push && !push_ok) ovf_q <= 1'b1;
      else if (clr_err)     ovf_q <= 1'b0;
      if (pop && !pop_ok)   unf_q <= 1'b1;
      else if (clr_err)     unf_q <= 1'b0;
    end
  end

`ifdef FIFO_FWFT_EN
  assign data_out   = st.empty ? '0 : head;
  assign data_valid = !st.empty;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= pop_ok;
      if (pop_ok) data_out <= head;
    end
  end
`endif

endmodule
